// File: rtl/sys_btn_pkg.sv
// Shared limits, defaults and helpers for the board button conditioner.
package sys_btn_pkg;

  localparam int SYS_BTN_MAX_CH  = 16;
  localparam int SYS_BTN_MAX_DEB = 16;
  // 50 MHz clk_sys / 100000 -> one sample tick every 2 ms
  localparam int SYS_BTN_DEF_DIV = 100000;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic lng;
  } sys_btn_chan_out_t;

  // Bits needed to hold 0..value-1, never less than 1.
  function automatic int sys_btn_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sys_btn_chan.sv
// One debounced button channel: sample shift register, level, edge pulses
// and (with SYS_BTN_LONGPRESS_EN) a saturating long-press counter.
module sys_btn_chan
  import sys_btn_pkg::*;
#(
  parameter int DEB_LEN = 8
`ifdef SYS_BTN_LONGPRESS_EN
  ,
  parameter int LONG_TICKS = 2000
`endif
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              tick,
  input  logic              sample,
  output sys_btn_chan_out_t chan_out
);

  logic [DEB_LEN-1:0] sh_reg;
  logic [DEB_LEN-1:0] sh_next;
  logic               level_reg;
  logic               level_next;
  logic               prev_level_reg;
  logic               long_pulse;

  // Level only moves once the whole window agrees; mixed windows hold it.
  always_comb begin
    sh_next    = sh_reg;
    level_next = level_reg;
    if (tick) begin
      sh_next = {sh_reg[DEB_LEN-2:0], sample};
      if (&sh_next) begin
        level_next = 1'b1;
      end else if (~|sh_next) begin
        level_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sh_reg         <= '0;
      level_reg      <= 1'b0;
      prev_level_reg <= 1'b0;
    end else begin
      sh_reg         <= sh_next;
      level_reg      <= level_next;
      prev_level_reg <= level_reg;
    end
  end

`ifdef SYS_BTN_LONGPRESS_EN
  localparam int LP_W = sys_btn_clog2(LONG_TICKS + 1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_TICKS);

  logic [LP_W-1:0] lp_cnt_reg;
  logic            long_reg;

  // Counts ticks spent pressed; fires once on reaching LP_MAX, then sticks.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lp_cnt_reg <= '0;
      long_reg   <= 1'b0;
    end else begin
      long_reg <= 1'b0;
      if (tick) begin
        if (!level_next) begin
          lp_cnt_reg <= '0;
        end else if (level_reg && (lp_cnt_reg != LP_MAX)) begin
          lp_cnt_reg <= lp_cnt_reg + LP_W'(1);
          long_reg   <= (lp_cnt_reg == (LP_MAX - LP_W'(1)));
        end
      end
    end
  end

  assign long_pulse = long_reg & ~reset;
`else
  assign long_pulse = 1'b0;
`endif

  always_comb begin
    chan_out.level = level_reg;
    chan_out.press = level_reg & ~prev_level_reg & ~reset;
    chan_out.rel   = ~level_reg & prev_level_reg & ~reset;
    chan_out.lng   = long_pulse;
  end

endmodule

// File: rtl/sys_btn_debounce.sv
// Multi-channel button conditioner: 2-flop synchronisers, shared prescaled
// sample tick and N_CH debounce channels. SYS_BTN_LONGPRESS_EN enables btn_long.
module sys_btn_debounce
  import sys_btn_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DIV        = SYS_BTN_DEF_DIV,
  parameter int DEB_LEN    = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int LONG_TICKS = 2000
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic            tick
);

  localparam int DIV_W = sys_btn_clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  if (N_CH < 1 || N_CH > SYS_BTN_MAX_CH || DIV < 2 || DEB_LEN < 2 ||
      DEB_LEN > SYS_BTN_MAX_DEB || LONG_TICKS < 1) begin : g_bad_params
    $error("sys_btn_debounce: parameter out of range");
  end

  logic [DIV_W-1:0] div_cnt_reg;
  logic [N_CH-1:0]  sync1_reg;
  logic [N_CH-1:0]  sync2_reg;
  logic [N_CH-1:0]  sample;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  assign tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Polarity is fixed after the synchroniser so the flops stay plain copies.
  assign sample = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    sys_btn_chan_out_t chan_out;

    sys_btn_chan #(
      .DEB_LEN    (DEB_LEN)
`ifdef SYS_BTN_LONGPRESS_EN
      ,
      .LONG_TICKS (LONG_TICKS)
`endif
    ) u_chan (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .tick     (tick),
      .sample   (sample[gi]),
      .chan_out (chan_out)
    );

    assign btn_level[gi]   = chan_out.level;
    assign btn_press[gi]   = chan_out.press;
    assign btn_release[gi] = chan_out.rel;
    assign btn_long[gi]    = chan_out.lng;
  end

endmodule

// File: doc/sys_btn_debounce.md
# sys_btn_debounce

Parametrised multi-channel button conditioner for the board I/O section of the system top. It synchronises N raw board buttons and debounces them on a shared prescaled sample tick. It produces clean levels, single-cycle press/release pulses and an optional long-press pulse per channel. It replaces the hard-coded two-button debouncer and feeds the HPS `gp_in` button bits and the core-reset and OSD logic.

## Interface
- `N_CH`, default 2: number of button channels (1..16).
- `DIV`, default 100000: prescaler period in `clk_sys` cycles (≥2).
- `DEB_LEN`, default 8: number of consecutive equal samples required to change a level (2..16).
- `ACTIVE_LOW`, default 1: when 1, `btn_raw` bits are inverted before sampling.
- `LONG_TICKS`, default 2000: ticks of continuous press before `btn_long` fires (≥1; used only with the macro).
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_raw`  in  N_CH  asynchronous raw button pins.
- `btn_level`  out  N_CH  debounced level, 1 = pressed.
- `btn_press`  out  N_CH  one-cycle pulse when the level goes 0→1.
- `btn_release`  out  N_CH  one-cycle pulse when the level goes 1→0.
- `btn_long`  out  N_CH  one-cycle pulse on the long-press threshold (tied 0 without the macro).
- `tick`  out  1  shared sample strobe, exported for the LED blinker.

## Operation
- Synchroniser: each bit passes through a 2-flop synchroniser, then is normalised to active-high (`ACTIVE_LOW` inversion applied after the synchroniser).
- Prescaler: counter `div_cnt` counts 0..DIV-1 and wraps. `tick`=1 for exactly the one cycle where `div_cnt`==DIV-1.
- Per channel on a tick cycle:
  - The shift register `sh[DEB_LEN-1:0]` shifts in the normalised sample.
  - Using the shifted value: all ones → level 1; all zeros → level 0; otherwise the level holds.
  - Register and level update on the same edge.
  - On non-tick cycles all per-channel state holds.
- `btn_press`/`btn_release` are asserted during the cycle in which the new `btn_level` is first visible, and deasserted the next cycle. They are derived from a registered previous level.
- Long press, per channel: saturating counter `lp_cnt` (width clog2(LONG_TICKS+1)).
  - Increments on each tick while the level is 1.
  - `btn_long` pulses for one cycle on the edge where `lp_cnt` becomes LONG_TICKS, then the counter saturates; no repeat pulse.
  - Cleared to 0 on the edge where the level becomes 0.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.

## Timing
- Reset values: `div_cnt`=0, `sh`=0, synchronisers=0, `btn_level`=0, all pulse outputs 0, `tick`=0, `lp_cnt`=0.
  - No press/release pulse is ever generated from reset state alone.
  - A button held through reset yields `btn_press` after DEB_LEN ticks.
- Input to first sample: 2 cycles of synchroniser plus wait for the next tick.
- Press-to-level latency: DEB_LEN ticks of stable input. Worst case 2 + DEB_LEN·DIV cycles.
- Glitch rejection: any opposite sample within the DEB_LEN window prevents the change.
- Reset asserted mid-debounce or mid-long-press: all state clears on that edge; no pulse is emitted in that cycle or the next.
- The first tick after reset occurs at cycle DIV-1 after reset deasserts.

## Configuration
- Macro `SYS_BTN_LONGPRESS_EN`.
- Defined: `lp_cnt` logic is present and `btn_long` behaves as above.
- Undefined: no long-press counters are instantiated, `btn_long` is constant 0, and `LONG_TICKS` is ignored.

## Structure
- Package `sys_btn_pkg`:
  - limits `SYS_BTN_MAX_CH`=16 and `SYS_BTN_MAX_DEB`=16;
  - a clog2 helper function;
  - the default DIV constant for a 50 MHz clock (100000 → 2 ms tick).
- Top `sys_btn_debounce` holds the prescaler and the synchronisers.
- Sub-module `sys_btn_chan` is instantiated N_CH times via generate. It holds the shift register, level, edge pulses and long-press counter, and takes `tick` as input.

## Test plan
- Reset/idle: N_CH=2, DIV=4, DEB_LEN=3, inputs released (1) → all outputs 0; `tick` at cycles 3, 7, 11… after reset.
- Clean press: drive ch0 low and hold → `btn_level[0]` rises on the 3rd tick edge after synchronisation, with a one-cycle `btn_press[0]`; ch1 unchanged.
- Glitch: ch0 low for 2 ticks, high for 1, low again → no level change until 3 further consecutive low samples.
- Release and simultaneity: both channels released on the same cycle → `btn_release` = 2'b11 for one cycle, levels 0.
- Long press (macro on, LONG_TICKS=5): hold ch1 → `btn_long[1]` pulses once on the 5th tick after the level rises; holding 20 more ticks → no further pulse; release and re-press → fires again.
- Reset mid-press: assert `reset` with ch0 level 1 and `lp_cnt`=3 → next cycle level 0, no release pulse, counters 0. Macro off build → `btn_long` constant 0 throughout.
